// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, stall hold register, branch redirect.
// Interrupt entry/return support is built only when FETCH_INTERRUPT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INT_VEC  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        Branch,
    input  logic [31:0] BrPC,
    input  logic        int_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] imem_addr,
    output logic        imem_rd,
    output logic [31:0] inst,
    output logic [31:0] PC,
    output logic        inst_valid,
    output logic        inter,
    output logic [31:0] ilr,
    output logic [1:0]  dbg_state
);

    // Handshakes: decode takes inst/PC in any cycle with inst_valid=1 and stall=0;
    // otherwise inst/PC/inter hold. imem takes a request in every cycle imem_rd=1 and
    // completes the oldest one with imem_valid=1; at most one request is in flight.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic [31:0] ilr_q;
    logic [31:0] hold_word_q;
    logic [31:0] hold_pc_q;
    logic        inst_valid_q;
    logic        inter_q;
    logic        in_handler_q;
    logic        pend_inter_q;

    logic        taken;
    logic        req_open;
    logic        still_open;
    logic        int_accept;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] next_seq_pc;

    assign taken       = inst_valid_q && !stall;
    assign req_open    = (state_q != S_HOLD);
    assign still_open  = req_open && !imem_valid;
    assign redirect    = Branch || int_accept;
    assign redirect_pc = Branch ? BrPC : INT_VEC;
    assign next_seq_pc = fetch_pc_q + 32'd1;

`ifdef FETCH_INTERRUPT_EN
    // Accept only while the request for fetch_pc is being issued and no stalled
    // instruction would be lost, so fetch_pc is exactly the return address.
    assign int_accept = int_req && !in_handler_q && !Branch &&
                        (state_q == S_REQ) && !(inst_valid_q && stall);
`else
    logic unused_int_req;
    assign unused_int_req = int_req;
    assign int_accept     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            inst_q       <= 32'd0;
            pc_q         <= 32'd0;
            ilr_q        <= 32'd0;
            hold_word_q  <= 32'd0;
            hold_pc_q    <= 32'd0;
            inst_valid_q <= 1'b0;
            inter_q      <= 1'b0;
            in_handler_q <= 1'b0;
            pend_inter_q <= 1'b0;
        end else begin
            if (taken) begin
                inst_valid_q <= 1'b0;
                inst_q       <= 32'd0;
                inter_q      <= 1'b0;
            end

            if (redirect) begin
                fetch_pc_q   <= redirect_pc;
                inst_valid_q <= 1'b0;
                inst_q       <= 32'd0;
                inter_q      <= 1'b0;
                state_q      <= still_open ? S_DROP : S_REQ;
            end else begin
                case (state_q)
                    S_REQ, S_WAIT: begin
                        if (imem_valid) begin
                            fetch_pc_q <= next_seq_pc;
                            if (stall) begin
                                hold_word_q <= imem_rdata;
                                hold_pc_q   <= fetch_pc_q;
                                state_q     <= S_HOLD;
                            end else begin
                                inst_q       <= imem_rdata;
                                pc_q         <= fetch_pc_q;
                                inst_valid_q <= 1'b1;
                                inter_q      <= pend_inter_q;
                                pend_inter_q <= 1'b0;
                                state_q      <= S_REQ;
                            end
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            inst_q       <= hold_word_q;
                            pc_q         <= hold_pc_q;
                            inst_valid_q <= 1'b1;
                            inter_q      <= pend_inter_q;
                            pend_inter_q <= 1'b0;
                            state_q      <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (imem_valid) begin
                            state_q <= S_REQ;
                        end
                    end
                    default: state_q <= S_REQ;
                endcase
            end

            // A Branch taken inside the handler is its return.
            if (int_accept) begin
                ilr_q        <= fetch_pc_q;
                in_handler_q <= 1'b1;
                pend_inter_q <= 1'b1;
            end else if (Branch && in_handler_q) begin
                in_handler_q <= 1'b0;
                pend_inter_q <= 1'b0;
            end
        end
    end

    // Gated by rst_n so the first request appears as soon as reset is released.
    assign imem_rd    = rst_n && (state_q == S_REQ);
    assign imem_addr  = fetch_pc_q;
    assign inst       = inst_q;
    assign PC         = pc_q;
    assign inst_valid = inst_valid_q;
    assign inter      = inter_q;
    assign ilr        = ilr_q;
    assign dbg_state  = state_q;

endmodule
